// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment table,
// the all-off pattern and the parameter legality ranges.
package sseg_pkg;

    localparam logic [6:0] SSEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for nibble values 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam int MIN_DIGITS   = 2;
    localparam int MAX_DIGITS   = 16;
    localparam int MIN_SCAN_DIV = 32;
    localparam int SUB_SLOTS    = 16;

    function automatic bit params_legal(input int num_digits, input int scan_div,
                                        input int blank_cycles);
        return (num_digits >= MIN_DIGITS) && (num_digits <= MAX_DIGITS) &&
               (scan_div >= MIN_SCAN_DIV) && ((scan_div % SUB_SLOTS) == 0) &&
               (blank_cycles >= 0) && (blank_cycles < (scan_div / SUB_SLOTS));
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; every nibble value has an entry
    always_comb begin
        seg = SSEG_OFF;
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/scan_sseg_mux.sv
// Time-multiplexed common-anode seven-segment driver with dead-time, PWM brightness
// and frame-aligned shadow loading. Define SSEG_LZB_EN for leading-zero blanking.
module scan_sseg_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] hex_digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    update_req,
    output logic                    update_ack,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int PCNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SUB_LEN = SCAN_DIV / SUB_SLOTS;
    localparam int SUBC_W  = $clog2(SUB_LEN);

    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);
    localparam logic [PCNT_W-1:0] BLANK_P  = PCNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SUBC_W-1:0] SUBC_MAX = SUBC_W'(SUB_LEN - 1);

    if (!params_legal(NUM_DIGITS, SCAN_DIV, BLANK_CYCLES)) begin : g_param_check
        $error("scan_sseg_mux: illegal NUM_DIGITS/SCAN_DIV/BLANK_CYCLES");
    end

    logic [PCNT_W-1:0]       pcnt_r;
    logic [SUBC_W-1:0]       subc_r;
    logic [3:0]              sub_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] shadow_hex_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [NUM_DIGITS-1:0]   shadow_en_r;
    logic                    load_r;

    logic                    bnd_s;
    logic                    lit_s;
    logic                    digit_blank_s;
    logic                    fs_s;
    logic [3:0]              cur_nib_s;
    logic [6:0]              dec_seg_s;
    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic                    dp_s;

    assign bnd_s = (pcnt_r == PCNT_MAX) && (idx_r == IDX_MAX);

    // Prescaler, sub-slot tracker and digit index; sub_r mirrors pcnt_r / SUB_LEN
    // without a divider because SCAN_DIV is an exact multiple of 16
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_r <= '0;
            subc_r <= '0;
            sub_r  <= 4'd0;
            idx_r  <= '0;
        end else if (pcnt_r == PCNT_MAX) begin
            pcnt_r <= '0;
            subc_r <= '0;
            sub_r  <= 4'd0;
            idx_r  <= (idx_r == IDX_MAX) ? '0 : idx_r + IDX_W'(1);
        end else begin
            pcnt_r <= pcnt_r + PCNT_W'(1);
            if (subc_r == SUBC_MAX) begin
                subc_r <= '0;
                sub_r  <= sub_r + 4'd1;
            end else begin
                subc_r <= subc_r + SUBC_W'(1);
            end
        end
    end

    // Shadow capture only at the frame boundary so a frame never mixes old and new data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_hex_r <= '0;
            shadow_dp_r  <= '0;
            shadow_en_r  <= '1;
            load_r       <= 1'b0;
        end else begin
            load_r <= bnd_s & update_req;
            if (bnd_s && update_req) begin
                shadow_hex_r <= hex_digits;
                shadow_dp_r  <= dp_in;
                shadow_en_r  <= digit_en;
            end else begin
                shadow_hex_r <= shadow_hex_r;
                shadow_dp_r  <= shadow_dp_r;
                shadow_en_r  <= shadow_en_r;
            end
        end
    end

`ifdef SSEG_LZB_EN
    logic [NUM_DIGITS-1:0] blank_r;
    logic [NUM_DIGITS-1:0] blank_s;
    logic                  zero_run_s;

    // Digit k blanks when it and every higher digit are zero; digit 0 never blanks
    always_comb begin
        blank_s    = '0;
        zero_run_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run_s = zero_run_s & (hex_digits[4*k +: 4] == 4'd0);
            blank_s[k] = zero_run_s;
        end
    end

    // Blank mask travels with the shadow so it adds no output latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_r <= '0;
        end else if (bnd_s && update_req) begin
            blank_r <= blank_s;
        end else begin
            blank_r <= blank_r;
        end
    end

    assign digit_blank_s = blank_r[idx_r];
`else
    assign digit_blank_s = 1'b0;
`endif

    assign cur_nib_s = shadow_hex_r[{idx_r, 2'b00} +: 4];

    sseg_decode u_decode (
        .nibble (cur_nib_s),
        .seg    (dec_seg_s)
    );

    // Anode/segment selection for the current slot; dead-time and PWM gate the anode
    always_comb begin
        an_s  = '0;
        seg_s = SSEG_OFF;
        dp_s  = 1'b1;
        lit_s = (pcnt_r >= BLANK_P) && (sub_r <= brightness) && shadow_en_r[idx_r];
        fs_s  = (pcnt_r == '0) && (idx_r == '0);
        if (lit_s) begin
            an_s[idx_r] = 1'b1;
            seg_s       = digit_blank_s ? SSEG_OFF : dec_seg_s;
            dp_s        = ~shadow_dp_r[idx_r];
        end else begin
            an_s  = '0;
            seg_s = SSEG_OFF;
            dp_s  = 1'b1;
        end
    end

    // Output registers; ack is delayed one extra stage to coincide with frame_start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an          <= '0;
            sseg        <= SSEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
            update_ack  <= 1'b0;
        end else begin
            an          <= an_s;
            sseg        <= seg_s;
            dp          <= dp_s;
            frame_start <= fs_s;
            update_ack  <= load_r;
        end
    end

endmodule
